// File: rtl/hdb_n_decoder_pkg.sv
// rtl/hdb_n_decoder_pkg.sv - line symbol encodings and symbol classes for the HDB-N receive path
package hdb_n_decoder_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b10;
    localparam logic [1:0] SYM_V    = 2'b11;

    typedef enum logic [1:0] {
        ZERO,
        MARK,
        VIOL,
        ILLEGAL
    } sym_class_e;

    // Polarity bit of a mark: 0 = positive, 1 = negative.
    function automatic logic sym_pol(input logic [1:0] sym);
        return sym == SYM_NEG;
    endfunction

endpackage

// File: rtl/hdb_n_decoder_if.sv
// rtl/hdb_n_decoder_if.sv - symbol input / decoded output bundle of the HDB-N decoder
interface hdb_n_decoder_if #(
    parameter int ERR_W = 8
) ();
    logic             in_valid;
    logic [1:0]       data_in;
    logic             err_clr;
    logic             out_valid;
    logic             data_out;
    logic             code_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, data_in, err_clr,
        input  out_valid, data_out, code_err, err_cnt
    );

    modport slave (
        input  in_valid, data_in, err_clr,
        output out_valid, data_out, code_err, err_cnt
    );
endinterface

// File: rtl/hdb_sym_classify.sv
// rtl/hdb_sym_classify.sv - combinational classification of one line symbol against the last mark polarity
module hdb_sym_classify
    import hdb_n_decoder_pkg::*;
#(
    parameter bit LEGACY_V = 1'b0
) (
    input  logic [1:0] sym_i,
    input  logic       last_pol_i,
    input  logic       have_pol_i,
    output sym_class_e cls_o,
    output logic       pol_o,
    output logic       polarised_o
);

    always_comb begin
        cls_o       = ZERO;
        pol_o       = sym_pol(sym_i);
        polarised_o = 1'b0;
        case (sym_i)
            SYM_ZERO: cls_o = ZERO;
            SYM_POS, SYM_NEG: begin
                polarised_o = 1'b1;
                cls_o       = (have_pol_i && (pol_o == last_pol_i)) ? VIOL : MARK;
            end
            SYM_V:    cls_o = LEGACY_V ? VIOL : ILLEGAL;
        endcase
    end

endmodule

// File: rtl/hdb_n_decoder.sv
// rtl/hdb_n_decoder.sv - HDB-N decoder: V detection, substitution removal, code-violation flagging and counting
module hdb_n_decoder
    import hdb_n_decoder_pkg::*;
#(
    parameter int N        = 4,
    parameter bit LEGACY_V = 1'b0,
    parameter int ERR_W    = 8
) (
    input logic             clk,
    input logic             rst,
    hdb_n_decoder_if.slave  bus
);

    localparam int              CW  = $clog2(N + 1);
    localparam logic [CW-1:0]   N_C = CW'(N);

    logic [N-1:0]     dl_q, dl_d;
    logic             last_pol_q, have_pol_q, last_vpol_q, have_vpol_q;
    logic [CW-1:0]    zrun_q, zrun_d;
    logic [CW-1:0]    prime_q;
    logic             out_valid_q, data_out_q, code_err_q;
    logic [ERR_W-1:0] err_cnt_q;

    sym_class_e       cls;
    logic             pol, polarised;
    logic             is_zero, is_v, push, err;

    hdb_sym_classify #(
        .LEGACY_V (LEGACY_V)
    ) u_classify (
        .sym_i       (bus.data_in),
        .last_pol_i  (last_pol_q),
        .have_pol_i  (have_pol_q),
        .cls_o       (cls),
        .pol_o       (pol),
        .polarised_o (polarised)
    );

    always_comb begin
        is_zero = (cls == ZERO) || (cls == ILLEGAL);
        is_v    = (cls == VIOL);
        push    = (cls == MARK);
        // A V pushes 0 and wipes the N-1 older samples, so the whole line ends up zero.
        dl_d    = is_v ? '0 : {dl_q[N-2:0], push};
        zrun_d  = '0;
        if (is_zero) begin
            zrun_d = (zrun_q == N_C) ? zrun_q : zrun_q + 1'b1;
        end
        err = (cls == ILLEGAL)
            || (is_zero && (zrun_q == N_C - 1'b1))
            || (is_v && polarised && have_vpol_q && (pol == last_vpol_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_q        <= '0;
            last_pol_q  <= 1'b0;
            have_pol_q  <= 1'b0;
            last_vpol_q <= 1'b0;
            have_vpol_q <= 1'b0;
            zrun_q      <= '0;
            prime_q     <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= 1'b0;
            code_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            if (bus.in_valid) begin
                dl_q        <= dl_d;
                data_out_q  <= dl_q[N-1];
                out_valid_q <= (prime_q == N_C);
                if (prime_q != N_C) begin
                    prime_q <= prime_q + 1'b1;
                end
                zrun_q     <= zrun_d;
                code_err_q <= err;
                if (polarised) begin
                    last_pol_q <= pol;
                    have_pol_q <= 1'b1;
                    if (is_v) begin
                        last_vpol_q <= pol;
                        have_vpol_q <= 1'b1;
                    end
                end
            end
            if (bus.err_clr) begin
                err_cnt_q <= '0;
            end else if (bus.in_valid && err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.code_err  = code_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hdb_n_decoder.sv
// tb/tb_hdb_n_decoder.sv - directed bench for hdb_n_decoder, N=4, one strict and one legacy-V instance
module tb_hdb_n_decoder;
    import hdb_n_decoder_pkg::*;

    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] M = 2'b10;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] X = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdb_n_decoder_if #(.ERR_W(8)) if0 ();
    hdb_n_decoder_if #(.ERR_W(8)) if1 ();

    hdb_n_decoder #(.N(4), .LEGACY_V(1'b0), .ERR_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    hdb_n_decoder #(.N(4), .LEGACY_V(1'b1), .ERR_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    int   total = 0;
    int   bad   = 0;
    logic q0[$];
    logic q1[$];
    int   cerr0, cerr1, nsent, first_ov, gap_ov;

    function automatic logic [31:0] packq(input bit which);
        logic [31:0] w = '0;
        if (!which) begin
            foreach (q0[i]) w = {w[30:0], q0[i]};
        end else begin
            foreach (q1[i]) w = {w[30:0], q1[i]};
        end
        return w;
    endfunction

    task automatic send(input logic [1:0] s, input logic v, input logic clr);
        if0.in_valid = v; if0.data_in = s; if0.err_clr = clr;
        if1.in_valid = v; if1.data_in = s; if1.err_clr = clr;
        @(posedge clk);
        #1;
        if (v) nsent++;
        if (if0.out_valid) begin
            q0.push_back(if0.data_out);
            if (first_ov < 0) first_ov = nsent;
        end
        if (if1.out_valid) q1.push_back(if1.data_out);
        if (if0.code_err) cerr0++;
        if (if1.code_err) cerr1++;
        if (!v && (if0.out_valid || if1.out_valid)) gap_ov++;
        if0.in_valid = 1'b0; if0.err_clr = 1'b0;
        if1.in_valid = 1'b0; if1.err_clr = 1'b0;
    endtask

    task automatic clear_log();
        q0.delete(); q1.delete();
        cerr0 = 0; cerr1 = 0; nsent = 0; first_ov = -1; gap_ov = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(Z, 1'b0, 1'b0);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic send_stream(input logic [1:0] s[], input int gaps);
        foreach (s[i]) begin
            send(s[i], 1'b1, 1'b0);
            for (int g = 0; g < gaps; g++) send(X, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) rst = 1'b0;
            send(Z, 1'b0, 1'b0);
            total++;
            if ({if0.out_valid, if0.data_out, if0.code_err, if0.err_cnt} !== 11'd0)
                begin bad++; $display("FAIL reset0 cyc%0d: got %h want 0", c, {if0.out_valid, if0.data_out, if0.code_err, if0.err_cnt}); end
            total++;
            if ({if1.out_valid, if1.data_out, if1.code_err, if1.err_cnt} !== 11'd0)
                begin bad++; $display("FAIL reset1 cyc%0d: got %h want 0", c, {if1.out_valid, if1.data_out, if1.code_err, if1.err_cnt}); end
        end
        clear_log();
    endtask

    task automatic test_ami();
        logic [1:0] s[] = '{P, M, P, M, Z, Z, Z, P, M, P, M};
        do_reset();
        send_stream(s, 0);
        total++;
        if (first_ov !== 5) begin bad++; $display("FAIL ami_latency: got %0d want 5", first_ov); end
        total++;
        if (q0.size() != 7 || packq(0) !== 32'h78) begin bad++; $display("FAIL ami_data0: got n=%0d %h want n=7 78", q0.size(), packq(0)); end
        total++;
        if (q1.size() != 7 || packq(1) !== 32'h78) begin bad++; $display("FAIL ami_data1: got n=%0d %h want n=7 78", q1.size(), packq(1)); end
        total++;
        if (cerr0 + cerr1 != 0) begin bad++; $display("FAIL ami_err: got %0d want 0", cerr0 + cerr1); end
    endtask

    task automatic test_b00v();
        logic [1:0] s[] = '{P, M, Z, Z, M, Z, Z, Z, P};
        do_reset();
        send_stream(s, 0);
        total++;
        if (q0.size() != 5 || packq(0) !== 32'h10) begin bad++; $display("FAIL b00v_data: got n=%0d %h want n=5 10", q0.size(), packq(0)); end
        total++;
        if (cerr0 != 0) begin bad++; $display("FAIL b00v_err: got %0d want 0", cerr0); end
    endtask

    task automatic test_zero_run();
        logic [1:0] s[] = '{Z, Z, Z};
        do_reset();
        send_stream(s, 0);
        total++;
        if (cerr0 != 0) begin bad++; $display("FAIL zrun3: got %0d want 0", cerr0); end
        send(Z, 1'b1, 1'b0);
        total++;
        if (cerr0 != 1 || !if0.code_err) begin bad++; $display("FAIL zrun4_pulse: got %0d want 1", cerr0); end
        total++;
        if (if1.err_cnt !== 8'd1) begin bad++; $display("FAIL zrun4_cnt: got %0d want 1", if1.err_cnt); end
    endtask

    task automatic test_vpol();
        logic [1:0] s[] = '{P, Z, Z, Z, P, Z, Z, Z, P};
        logic [1:0] t[] = '{Z, Z, Z, P};
        logic [1:0] u[] = '{Z, Z, Z};
        do_reset();
        send_stream(s, 0);
        total++;
        if (cerr0 != 1) begin bad++; $display("FAIL vpol_pulses: got %0d want 1", cerr0); end
        total++;
        if (if0.err_cnt !== 8'd1) begin bad++; $display("FAIL vpol_cnt: got %0d want 1", if0.err_cnt); end
        send(Z, 1'b0, 1'b1);
        total++;
        if (if0.err_cnt !== 8'd0) begin bad++; $display("FAIL errclr: got %0d want 0", if0.err_cnt); end
        send_stream(t, 0);
        total++;
        if (if0.err_cnt !== 8'd1) begin bad++; $display("FAIL vpol_cnt2: got %0d want 1", if0.err_cnt); end
        send_stream(u, 0);
        send(P, 1'b1, 1'b1);
        total++;
        if (!if0.code_err || if0.err_cnt !== 8'd0)
            begin bad++; $display("FAIL clr_wins: got err=%0b cnt=%0d want err=1 cnt=0", if0.code_err, if0.err_cnt); end
    endtask

    task automatic test_gaps();
        logic [1:0] s[] = '{P, M, P, M, Z, Z, Z, P, M, P, M};
        do_reset();
        send_stream(s, 2);
        total++;
        if (q0.size() != 7 || packq(0) !== 32'h78) begin bad++; $display("FAIL gap_data: got n=%0d %h want n=7 78", q0.size(), packq(0)); end
        total++;
        if (gap_ov != 0) begin bad++; $display("FAIL gap_ov: got %0d want 0", gap_ov); end
        total++;
        if (cerr0 != 0) begin bad++; $display("FAIL gap_err: got %0d want 0", cerr0); end
    endtask

    task automatic test_legacy();
        logic [1:0] s[] = '{P, Z, Z, Z, X, M, Z, Z, P};
        do_reset();
        send_stream(s, 0);
        total++;
        if (q1.size() != 5 || packq(1) !== 32'h10) begin bad++; $display("FAIL legacy1_data: got n=%0d %h want n=5 10", q1.size(), packq(1)); end
        total++;
        if (cerr1 != 0) begin bad++; $display("FAIL legacy1_err: got %0d want 0", cerr1); end
        total++;
        if (q0.size() != 5 || packq(0) !== 32'h10) begin bad++; $display("FAIL legacy0_data: got n=%0d %h want n=5 10", q0.size(), packq(0)); end
        total++;
        if (cerr0 != 1 || if0.err_cnt !== 8'd1) begin bad++; $display("FAIL legacy0_err: got %0d cnt=%0d want 1 cnt=1", cerr0, if0.err_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [1:0] s[] = '{P, M, P, M, P};
        logic [1:0] t[] = '{M, P, M, P};
        do_reset();
        send_stream(s, 0);
        total++;
        if (q0.size() != 1) begin bad++; $display("FAIL pre_rst: got n=%0d want 1", q0.size()); end
        rst = 1'b1;
        send(M, 1'b1, 1'b0);
        rst = 1'b0;
        total++;
        if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL rst_prio: got %0b want 0", if0.out_valid); end
        clear_log();
        send_stream(t, 0);
        total++;
        if (q0.size() != 0) begin bad++; $display("FAIL reprime: got n=%0d want 0", q0.size()); end
        send(M, 1'b1, 1'b0);
        total++;
        if (q0.size() != 1 || q0[0] !== 1'b1) begin bad++; $display("FAIL reprime_first: got n=%0d want n=1 bit 1", q0.size()); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 255; i++) send(X, 1'b1, 1'b0);
        total++;
        if (if0.err_cnt !== 8'hFF) begin bad++; $display("FAIL sat255: got %0d want 255", if0.err_cnt); end
        send(X, 1'b1, 1'b0);
        total++;
        if (if0.err_cnt !== 8'hFF || !if0.code_err) begin bad++; $display("FAIL sat256: got %0d err=%0b want 255 err=1", if0.err_cnt, if0.code_err); end
        total++;
        if (cerr1 != 0 || if1.err_cnt !== 8'd0) begin bad++; $display("FAIL sat_legacy: got %0d cnt=%0d want 0", cerr1, if1.err_cnt); end
        send(Z, 1'b0, 1'b1);
        total++;
        if (if0.err_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", if0.err_cnt); end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.data_in = Z; if0.err_clr = 1'b0;
        if1.in_valid = 1'b0; if1.data_in = Z; if1.err_clr = 1'b0;
        clear_log();
        test_reset();
        test_ami();
        test_b00v();
        test_zero_run();
        test_vpol();
        test_gaps();
        test_legacy();
        test_mid_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
